// File: rtl/dmem_access_ctrl.sv
// Memory-access sequencer between the RV32IM pipeline and a word-only data memory.
// Turns byte/half/word loads and stores into aligned word accesses, with read-modify-write for sub-word stores.
module dmem_access_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  cpu_read,
   input  logic [2:0]  cpu_write,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_busywait,
   output logic        access_fault,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_busywait
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, DONE, FAULT} state_t;

   state_t           state, state_nx;
   logic [2:0]       f3_q;
   logic [1:0]       sz_q;
   logic [1:0]       lane_q;
   logic [31:0]      wdata_q;
   logic [CNT_W-1:0] tmo_cnt;
   logic             ld_v, st_v, req, legal, tmo_hit, busy_state;

   function automatic logic request_legal(input logic [3:0] rd, input logic [2:0] wr,
                                          input logic [1:0] a);
      logic ok;
      ok = !(rd[3] && wr[2]);
      if (rd[3]) begin
         case (rd[2:0])
            3'b000, 3'b100: begin end
            3'b001, 3'b101: if (a[0]) ok = 1'b0;
            3'b010:         if (a != 2'b00) ok = 1'b0;
            default:        ok = 1'b0;
         endcase
      end
      if (wr[2]) begin
         case (wr[1:0])
            2'b00:   begin end
            2'b01:   if (a[0]) ok = 1'b0;
            2'b10:   if (a != 2'b00) ok = 1'b0;
            default: ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] lane);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] ext;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  ext = 32'(b);
         3'b001:  ext = 32'(h);
         3'b100:  ext = {24'd0, b};
         3'b101:  ext = {16'd0, h};
         default: ext = word;
      endcase
      return ext;
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [1:0] sz, input logic [1:0] lane);
      logic [31:0] m;
      m = word;
      if (sz == 2'b00)
         m[{lane, 3'b000} +: 8] = wdata[7:0];
      else if (sz == 2'b01) begin
         if (lane[1]) m[31:16] = wdata[15:0];
         else         m[15:0]  = wdata[15:0];
      end else
         m = wdata;
      return m;
   endfunction

   assign ld_v       = cpu_read[3];
   assign st_v       = cpu_write[2];
   assign req        = ld_v | st_v;
   assign legal      = req & request_legal(cpu_read, cpu_write, cpu_addr[1:0]);
   assign busy_state = (state == RD) || (state == RMW_RD) || (state == WR);
   assign tmo_hit    = (TIMEOUT != 0) && mem_busywait && (tmo_cnt == TMO_LAST);

   always_comb begin
      state_nx     = state;
      cpu_busywait = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      access_fault = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (!legal)
                  state_nx = FAULT;
               else begin
                  cpu_busywait = 1'b1;
                  if (ld_v)                        state_nx = RD;
                  else if (cpu_write[1:0] == 2'b10) state_nx = WR;
                  else                             state_nx = RMW_RD;
               end
            end
         end
         RD: begin
            cpu_busywait = 1'b1;
            mem_read     = 1'b1;
            if (!mem_busywait) state_nx = DONE;
            else if (tmo_hit)  state_nx = FAULT;
         end
         RMW_RD: begin
            cpu_busywait = 1'b1;
            mem_read     = 1'b1;
            if (!mem_busywait) state_nx = WR;
            else if (tmo_hit)  state_nx = FAULT;
         end
         WR: begin
            cpu_busywait = 1'b1;
            mem_write    = 1'b1;
            if (!mem_busywait) state_nx = DONE;
            else if (tmo_hit)  state_nx = FAULT;
         end
         DONE:    state_nx = IDLE;
         FAULT: begin
            access_fault = 1'b1;
            state_nx     = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Request is latched in IDLE so later changes on cpu_* during the stall are ignored.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         tmo_cnt   <= '0;
         cpu_rdata <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         f3_q      <= '0;
         sz_q      <= '0;
         lane_q    <= '0;
         wdata_q   <= '0;
      end else begin
         state <= state_nx;
         if (state_nx != state)
            tmo_cnt <= '0;
         else if (busy_state && mem_busywait)
            tmo_cnt <= tmo_cnt + 1'b1;
         case (state)
            IDLE: begin
               if (legal) begin
                  mem_addr <= {cpu_addr[31:2], 2'b00};
                  f3_q     <= cpu_read[2:0];
                  sz_q     <= cpu_write[1:0];
                  lane_q   <= cpu_addr[1:0];
                  wdata_q  <= cpu_wdata;
                  if (st_v && (cpu_write[1:0] == 2'b10))
                     mem_wdata <= cpu_wdata;
               end
            end
            RD:      if (!mem_busywait) cpu_rdata <= load_extract(mem_rdata, f3_q, lane_q);
            RMW_RD:  if (!mem_busywait) mem_wdata <= store_merge(mem_rdata, wdata_q, sz_q, lane_q);
            default: begin end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: a 16-word memory model answers the DUT,
// a reference model predicts every response, and a forked monitor checks them.
module tb_dmem_access_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  cpu_read;
   logic [2:0]  cpu_write;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_busywait, access_fault, mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_busywait = 1'b0;

   always #5 clock = ~clock;

   dmem_access_ctrl #(.TIMEOUT(4)) dut (
      .clock(clock), .reset(reset),
      .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_busywait(cpu_busywait), .access_fault(access_fault),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_busywait(mem_busywait)
   );

   logic [31:0] mem [16];
   logic [31:0] ref_mem [16];
   logic        poke = 1'b0;
   logic [3:0]  poke_idx;
   logic [31:0] poke_val;
   int          bmode = 0;
   int          run = 0;
   int          hold_used = 0;

   assign mem_rdata = mem[mem_addr[5:2]];

   always @(posedge clock) begin
      if (poke)
         mem[poke_idx] <= poke_val;
      else if (!reset && mem_write && !mem_busywait)
         mem[mem_addr[5:2]] <= mem_wdata;
   end

   // 0: zero-wait, 1: random (at most 2 consecutive), 2: stuck, 3: first 3 strobe cycles busy
   always @(negedge clock) begin
      case (bmode)
         0: mem_busywait <= 1'b0;
         1: begin
            if (run < 2 && $urandom_range(0, 2) == 0) begin
               mem_busywait <= 1'b1;
               run <= run + 1;
            end else begin
               mem_busywait <= 1'b0;
               run <= 0;
            end
         end
         2: mem_busywait <= 1'b1;
         default: begin
            mem_busywait <= (mem_read || mem_write) && hold_used < 3;
            if ((mem_read || mem_write) && hold_used < 3) hold_used <= hold_used + 1;
         end
      endcase
      if (bmode != 3) hold_used <= 0;
   end

   typedef struct {
      bit          fault;
      bit          is_load;
      logic [31:0] data;
      int          idx;
   } exp_t;

   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] cur_addr = '0;
   logic [31:0] cur_wword = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_legal(logic [3:0] rd, logic [2:0] wr, logic [31:0] a);
      if (rd[3] && wr[2]) return 0;
      if (rd[3]) begin
         if (rd[2:0] == 3 || rd[2:0] == 6 || rd[2:0] == 7) return 0;
         if ((rd[2:0] == 1 || rd[2:0] == 5) && (a % 2) != 0) return 0;
         if (rd[2:0] == 2 && (a % 4) != 0) return 0;
      end
      if (wr[2]) begin
         if (wr[1:0] == 3) return 0;
         if (wr[1:0] == 1 && (a % 2) != 0) return 0;
         if (wr[1:0] == 2 && (a % 4) != 0) return 0;
      end
      return 1;
   endfunction

   function automatic logic [31:0] model_load(logic [31:0] w, logic [2:0] f3, logic [31:0] a);
      int unsigned bsh, hsh;
      logic [31:0] b, h;
      bsh = (a % 4) * 8;
      hsh = ((a % 4) / 2) * 16;
      b = (w >> bsh) & 32'hFF;
      h = (w >> hsh) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] model_store(logic [31:0] old, logic [31:0] wd, logic [1:0] sz,
                                               logic [31:0] a);
      int unsigned bsh, hsh;
      logic [31:0] mask;
      bsh = (a % 4) * 8;
      hsh = ((a % 4) / 2) * 16;
      if (sz == 2) return wd;
      if (sz == 0) begin
         mask = 32'hFF << bsh;
         return (old & ~mask) | ((wd & 32'hFF) << bsh);
      end
      mask = 32'hFFFF << hsh;
      return (old & ~mask) | ((wd & 32'hFFFF) << hsh);
   endfunction

   task automatic poke_word(input int idx, input logic [31:0] val);
      poke_idx = 4'(idx);
      poke_val = val;
      poke     = 1'b1;
      @(posedge clock);
      #1 poke = 1'b0;
      ref_mem[idx] = val;
   endtask

   task automatic monitor();
      bit   prev_busy = 0;
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset) prev_busy = 0;
         else begin
            if (mem_read || mem_write) begin
               check("strobe_exclusive", 32'(mem_read & mem_write), 32'd0);
               check("mem_addr", mem_addr, {cur_addr[31:2], 2'b00});
               if (mem_write) check("mem_wdata", mem_wdata, cur_wword);
            end
            if (access_fault || (prev_busy && !cpu_busywait)) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_response: fault=%0b with no pending request", access_fault);
               end else begin
                  e = exp_q.pop_front();
                  check("resp_fault", 32'(access_fault), 32'(e.fault));
                  if (e.is_load && !e.fault) check("load_data", cpu_rdata, e.data);
                  else                       check("mem_word", mem[e.idx], e.data);
               end
            end
            prev_busy = cpu_busywait;
         end
      end
   endtask

   // Issues one request, holds it (scrambling cpu_* during the stall) until the DUT releases it.
   task automatic do_req(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit force_fault,
                         input int exp_stall, input int exp_rd, input int exp_wr);
      exp_t e;
      bit   lg, done;
      int   idx, stalls, nrd, nwr, n;
      idx = int'(addr[5:2]);
      lg  = model_legal(rd, wr, addr) && !force_fault;
      e.fault = !lg;
      e.idx   = idx;
      e.is_load = lg && rd[3];
      if (lg && rd[3])  e.data = model_load(ref_mem[idx], rd[2:0], addr);
      else if (lg)      e.data = model_store(ref_mem[idx], wdata, wr[1:0], addr);
      else              e.data = ref_mem[idx];
      if (lg && !rd[3]) ref_mem[idx] = e.data;
      cur_addr  = addr;
      cur_wword = e.data;
      exp_q.push_back(e);
      cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wdata;
      stalls = 0; nrd = 0; nwr = 0; n = 0; done = 0;
      while (!done) begin
         @(negedge clock);
         nrd += int'(mem_read);
         nwr += int'(mem_write);
         if (!cpu_busywait) done = 1;
         else begin
            stalls++;
            n++;
            if (n > 100) begin
               checks++;
               errors++;
               $display("FAIL stall_bound: busywait still high after %0d cycles", n);
               done = 1;
            end else begin
               @(posedge clock);
               #1;
               cpu_read = 4'($urandom); cpu_write = 3'($urandom);
               cpu_addr = $urandom;     cpu_wdata = $urandom;
            end
         end
      end
      @(posedge clock);
      #1;
      cpu_read = '0; cpu_write = '0; cpu_addr = '0; cpu_wdata = '0;
      if (!lg && !force_fault) begin
         @(posedge clock);
         #1;
      end
      if (exp_stall >= 0) check("stall_cycles", 32'(stalls), 32'(exp_stall));
      if (exp_rd >= 0)    check("read_strobes", 32'(nrd), 32'(exp_rd));
      if (exp_wr >= 0)    check("write_strobes", 32'(nwr), 32'(exp_wr));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  f3s [5];
      logic [2:0]  f3;
      logic [1:0]  sz;
      logic [31:0] addr;
      int          k;
      f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      reset = 1'b1;
      cpu_read = '0; cpu_write = '0; cpu_addr = '0; cpu_wdata = '0;
      fork
         monitor();
      join_none
      repeat (2) @(posedge clock);
      #1;
      check("rst_cpu_rdata", cpu_rdata, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_mem_read", 32'(mem_read), 32'd0);
      check("rst_mem_write", 32'(mem_write), 32'd0);
      check("rst_access_fault", 32'(access_fault), 32'd0);
      check("rst_busywait", 32'(cpu_busywait), 32'd0);
      for (int i = 0; i < 16; i++) poke_word(i, $urandom);
      reset = 1'b0;
      @(posedge clock);
      #1;

      poke_word(4, 32'h8899_AABB);
      do_req(4'b1010, 3'b000, 32'h10, 32'h0, 0, 2, 1, 0);
      check("lw_value", cpu_rdata, 32'h8899_AABB);

      poke_word(4, 32'h80FF_0102);
      do_req(4'b1000, 3'b000, 32'h13, 32'h0, 0, 2, 1, 0);
      check("lb_value", cpu_rdata, 32'hFFFF_FF80);
      do_req(4'b1100, 3'b000, 32'h13, 32'h0, 0, 2, 1, 0);
      check("lbu_value", cpu_rdata, 32'h0000_0080);
      do_req(4'b1001, 3'b000, 32'h12, 32'h0, 0, 2, 1, 0);
      check("lh_value", cpu_rdata, 32'hFFFF_80FF);

      poke_word(8, 32'h1122_3344);
      do_req(4'b0000, 3'b100, 32'h21, 32'h55, 0, 3, 1, 1);
      check("sb_word", mem[8], 32'h1122_5544);

      do_req(4'b0000, 3'b101, 32'h23, 32'hBEEF, 0, 0, 0, 0);
      check("fault_keeps_rdata", cpu_rdata, 32'hFFFF_80FF);
      do_req(4'b1010, 3'b110, 32'h10, 32'h1234, 0, 0, 0, 0);

      bmode = 3;
      do_req(4'b0000, 3'b110, 32'h2C, 32'hCAFE_F00D, 0, 5, 0, 4);
      bmode = 0;
      check("sw_word", mem[11], 32'hCAFE_F00D);

      bmode = 2;
      do_req(4'b1010, 3'b000, 32'h30, 32'h0, 1, 5, 4, 0);
      bmode = 0;

      poke_word(9, 32'hA5A5_5A5A);
      bmode    = 2;
      cur_addr = 32'h24;
      cpu_read = 4'b0000; cpu_write = 3'b100; cpu_addr = 32'h24; cpu_wdata = 32'h77;
      @(posedge clock);
      #1;
      @(negedge clock);
      check("rmw_read_strobe", 32'(mem_read), 32'd1);
      cpu_write = '0; cpu_addr = '0; cpu_wdata = '0;
      #1 reset = 1'b1;
      #1;
      check("abort_mem_read", 32'(mem_read), 32'd0);
      check("abort_mem_write", 32'(mem_write), 32'd0);
      check("abort_busywait", 32'(cpu_busywait), 32'd0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      bmode = 0;
      repeat (3) @(posedge clock);
      #1;
      check("abort_word_kept", mem[9], 32'hA5A5_5A5A);

      bmode = 1;
      for (int i = 0; i < 250; i++) begin
         k  = $urandom_range(0, 7);
         f3 = f3s[$urandom_range(0, 4)];
         sz = 2'($urandom_range(0, 2));
         if ($urandom_range(0, 7) == 0) begin
            f3 = 3'($urandom);
            sz = 2'($urandom);
         end
         addr = {26'($urandom), 6'($urandom_range(0, 63))};
         if ($urandom_range(0, 3) != 0) begin
            if (k < 4) begin
               if (f3[1:0] == 2'd1) addr[0] = 1'b0;
               if (f3[1:0] == 2'd2) addr[1:0] = 2'b00;
            end else begin
               if (sz == 2'd1) addr[0] = 1'b0;
               if (sz == 2'd2) addr[1:0] = 2'b00;
            end
         end
         do_req({(k < 4) || (k == 7), f3}, {k >= 4, sz}, addr, $urandom, 0, -1, -1, -1);
         repeat ($urandom_range(0, 2)) @(posedge clock);
         #1;
      end
      bmode = 0;
      repeat (4) @(posedge clock);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
